// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer:
// FSM states, opcodes, branch codes and instruction field positions.
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_HALTED
   } state_e;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_HALT = 4'd1;

   localparam logic [1:0] BR_SEQ = 2'b00;
   localparam logic [1:0] BR_REL = 2'b01;
   localparam logic [1:0] BR_ABS = 2'b10;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RA_HI  = 11;
   localparam int RA_LO  = 8;
   localparam int RB_HI  = 7;
   localparam int RB_LO  = 4;
   localparam int RC_HI  = 3;
   localparam int RC_LO  = 0;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   function automatic logic [3:0] instr_op(input logic [15:0] w);
      return w[OP_HI:OP_LO];
   endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// Combinational next-PC selection: sequential, relative or absolute.
// All arithmetic wraps modulo 2^ADDR_W.
module next_pc_calc
   import fetch_sequencer_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [7:0]        imm8_i,
   input  logic [1:0]        branch_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] npc_o
);

   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] offset;

   assign seq_pc = pc_i + ADDR_W'(1);
   assign offset = {{(ADDR_W-8){imm8_i[7]}}, imm8_i};

   always_comb begin
      npc_o = seq_pc;
      unique case (branch_i)
         BR_REL:  npc_o = seq_pc + offset;
         BR_ABS:  npc_o = target_i;
         default: npc_o = seq_pc;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, instruction fetch handshake, decode strobe and
// retire counter for the 16-bit ALU datapath.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OP  = OP_HALT
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   output logic              IMEM_REQ,
   output logic [ADDR_W-1:0] IMEM_ADDR,
   input  logic              IMEM_ACK,
   input  logic [15:0]       IMEM_DATA,
   output logic [3:0]        OP,
   output logic [3:0]        RA,
   output logic [3:0]        RB,
   output logic [3:0]        RC,
   output logic [7:0]        IMM8,
   output logic              OP_VALID,
   input  logic [1:0]        BRANCH,
   input  logic [ADDR_W-1:0] BR_TARGET,
   output logic [ADDR_W-1:0] PC,
   output logic              HALTED,
   output logic [15:0]       RETIRED
);

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [15:0]       ir_q;
   logic              opv_q;
   logic              req_q;
   logic              halted_q;
   logic [15:0]       retired_q;

   next_pc_calc #(
      .ADDR_W (ADDR_W)
   ) u_npc (
      .pc_i     (pc_q),
      .imm8_i   (ir_q[IMM_HI:IMM_LO]),
      .branch_i (BRANCH),
      .target_i (BR_TARGET),
      .npc_o    (pc_d)
   );

   // Decoded fields come straight off the IR register, so they are
   // registered, update on the ack edge and hold until the next fetch.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         opv_q     <= 1'b0;
         req_q     <= 1'b0;
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (START) begin
                  state_q <= ST_FETCH;
                  req_q   <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (IMEM_ACK) begin
                  ir_q    <= IMEM_DATA;
                  opv_q   <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               opv_q <= 1'b0;
               if (instr_op(ir_q) == HALT_OP) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               pc_q      <= pc_d;
               retired_q <= retired_q + 16'd1;
               req_q     <= 1'b1;
               state_q   <= ST_FETCH;
            end
            ST_HALTED: begin
               if (START) begin
                  pc_q     <= RESET_PC;
                  halted_q <= 1'b0;
                  req_q    <= 1'b1;
                  state_q  <= ST_FETCH;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign IMEM_REQ  = req_q;
   assign IMEM_ADDR = pc_q;
   assign PC        = pc_q;
   assign OP        = ir_q[OP_HI:OP_LO];
   assign RA        = ir_q[RA_HI:RA_LO];
   assign RB        = ir_q[RB_HI:RB_LO];
   assign RC        = ir_q[RC_HI:RC_LO];
   assign IMM8      = ir_q[IMM_HI:IMM_LO];
   assign OP_VALID  = opv_q;
   assign HALTED    = halted_q;
   assign RETIRED   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: behavioural reference model plus directed
// and randomized stimulus for fetch_sequencer.
module tb_fetch_sequencer;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        START;
   logic        IMEM_REQ;
   logic [15:0] IMEM_ADDR;
   logic        IMEM_ACK;
   logic [15:0] IMEM_DATA;
   logic [3:0]  OP, RA, RB, RC;
   logic [7:0]  IMM8;
   logic        OP_VALID;
   logic [1:0]  BRANCH;
   logic [15:0] BR_TARGET;
   logic [15:0] PC;
   logic        HALTED;
   logic [15:0] RETIRED;

   int checks = 0;
   int errors = 0;

   fetch_sequencer dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .START     (START),
      .IMEM_REQ  (IMEM_REQ),
      .IMEM_ADDR (IMEM_ADDR),
      .IMEM_ACK  (IMEM_ACK),
      .IMEM_DATA (IMEM_DATA),
      .OP        (OP),
      .RA        (RA),
      .RB        (RB),
      .RC        (RC),
      .IMM8      (IMM8),
      .OP_VALID  (OP_VALID),
      .BRANCH    (BRANCH),
      .BR_TARGET (BR_TARGET),
      .PC        (PC),
      .HALTED    (HALTED),
      .RETIRED   (RETIRED)
   );

   always #5 CLK = ~CLK;

   // Reference model: which phase the machine is in, plus PC, last
   // fetched word and retire count.
   localparam int P_IDLE   = 0;
   localparam int P_FETCH  = 1;
   localparam int P_DECODE = 2;
   localparam int P_EXEC   = 3;
   localparam int P_HALT   = 4;

   int          m_phase;
   logic [15:0] m_pc;
   logic [15:0] m_ir;
   logic [15:0] m_ret;

   function automatic void model_reset();
      m_phase = P_IDLE;
      m_pc    = 16'h0000;
      m_ir    = 16'h0000;
      m_ret   = 16'h0000;
   endfunction

   function automatic void model_step(input logic s, input logic a,
                                      input logic [15:0] d,
                                      input logic [1:0] b,
                                      input logic [15:0] t);
      logic [15:0] off;
      off = {{8{m_ir[7]}}, m_ir[7:0]};
      case (m_phase)
         P_IDLE:   if (s) m_phase = P_FETCH;
         P_FETCH:  if (a) begin m_ir = d; m_phase = P_DECODE; end
         P_DECODE: m_phase = (m_ir[15:12] == 4'd1) ? P_HALT : P_EXEC;
         P_EXEC: begin
            if (b == 2'b01)      m_pc = m_pc + 16'd1 + off;
            else if (b == 2'b10) m_pc = t;
            else                 m_pc = m_pc + 16'd1;
            m_ret   = m_ret + 16'd1;
            m_phase = P_FETCH;
         end
         P_HALT: if (s) begin m_pc = 16'h0000; m_phase = P_FETCH; end
         default: m_phase = P_IDLE;
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h",
                  name, $time, act, exp);
      end
   endtask

   task automatic check_all();
      chk("req",     16'(IMEM_REQ),  16'(m_phase == P_FETCH));
      chk("addr",    IMEM_ADDR,      m_pc);
      chk("pc",      PC,             m_pc);
      chk("op",      16'(OP),        16'(m_ir[15:12]));
      chk("ra",      16'(RA),        16'(m_ir[11:8]));
      chk("rb",      16'(RB),        16'(m_ir[7:4]));
      chk("rc",      16'(RC),        16'(m_ir[3:0]));
      chk("imm8",    16'(IMM8),      16'(m_ir[7:0]));
      chk("opvalid", 16'(OP_VALID),  16'(m_phase == P_DECODE));
      chk("halted",  16'(HALTED),    16'(m_phase == P_HALT));
      chk("retired", RETIRED,        m_ret);
   endtask

   task automatic tick(input logic s, input logic a,
                       input logic [15:0] d, input logic [1:0] b,
                       input logic [15:0] t);
      START     = s;
      IMEM_ACK  = a;
      IMEM_DATA = d;
      BRANCH    = b;
      BR_TARGET = t;
      model_step(s, a, d, b, t);
      @(negedge CLK);
      check_all();
   endtask

   // Runs one instruction starting in FETCH; ends with EXEC done.
   task automatic run_instr(input logic [15:0] word, input int waits,
                            input logic [1:0] b, input logic [15:0] t);
      for (int i = 0; i < waits; i++) begin
         tick(1'b0, 1'b0, 16'hDEAD, 2'b00, 16'h0);
         chk("wait_req", 16'(IMEM_REQ), 16'h1);
      end
      tick(1'b0, 1'b1, word, 2'b00, 16'h0);
      chk("dec_strobe", 16'(OP_VALID), 16'h1);
      tick(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
      chk("exec_strobe", 16'(OP_VALID), 16'h0);
      tick(1'b0, 1'b0, 16'h0, b, t);
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      model_reset();
      repeat (3) @(negedge CLK);
      check_all();
      RST_N = 1'b1;
   endtask

   initial begin
      RST_N     = 1'b0;
      START     = 1'b0;
      IMEM_ACK  = 1'b0;
      IMEM_DATA = 16'h0;
      BRANCH    = 2'b00;
      BR_TARGET = 16'h0;
      model_reset();
      @(negedge CLK);
      do_reset();
      chk("rst_pc",  PC,               16'h0000);
      chk("rst_req", 16'(IMEM_REQ),    16'h0);
      chk("rst_ret", RETIRED,          16'h0000);

      tick(1'b1, 1'b0, 16'h0, 2'b00, 16'h0);
      chk("first_req",  16'(IMEM_REQ), 16'h1);
      chk("first_addr", IMEM_ADDR,     16'h0000);
      tick(1'b0, 1'b1, 16'h2345, 2'b00, 16'h0);
      chk("dec_op",   16'(OP),   16'h2);
      chk("dec_ra",   16'(RA),   16'h3);
      chk("dec_rb",   16'(RB),   16'h4);
      chk("dec_rc",   16'(RC),   16'h5);
      chk("dec_imm",  16'(IMM8), 16'h45);
      chk("dec_v",    16'(OP_VALID), 16'h1);
      tick(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
      chk("exec_v",   16'(OP_VALID), 16'h0);
      tick(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
      chk("seq_pc",   PC,      16'h0001);
      chk("seq_ret",  RETIRED, 16'h0001);

      run_instr(16'h3000, 4, 2'b10, 16'h0010);
      chk("wait_addr", IMEM_ADDR, 16'h0010);
      run_instr(16'h40FE, 0, 2'b01, 16'h0);
      chk("rel_neg", PC, 16'h000F);
      run_instr(16'h5000, 1, 2'b10, 16'h1234);
      chk("abs", PC, 16'h1234);
      run_instr(16'h6000, 0, 2'b11, 16'h0);
      chk("br11", PC, 16'h1235);
      run_instr(16'h6000, 2, 2'b10, 16'hFFFF);
      run_instr(16'h7000, 0, 2'b00, 16'h0);
      chk("wrap_seq", PC, 16'h0000);
      run_instr(16'h8080, 0, 2'b01, 16'h0);
      chk("wrap_rel", PC, 16'hFF81);
      run_instr(16'h9000, 0, 2'b10, 16'h0005);
      chk("ret_cnt", RETIRED, 16'd9);

      tick(1'b0, 1'b1, 16'h1000, 2'b00, 16'h0);
      chk("halt_v",  16'(OP_VALID), 16'h1);
      chk("halt_op", 16'(OP),       16'h1);
      tick(1'b1, 1'b0, 16'h0, 2'b00, 16'h0);
      chk("halted",   16'(HALTED),   16'h1);
      chk("halt_pc",  PC,            16'h0005);
      chk("halt_req", 16'(IMEM_REQ), 16'h0);
      chk("halt_ret", RETIRED,       16'd9);
      tick(1'b0, 1'b1, 16'h2222, 2'b00, 16'h0);
      tick(1'b1, 1'b0, 16'h0, 2'b00, 16'h0);
      chk("restart_pc",  PC,            16'h0000);
      chk("restart_req", 16'(IMEM_REQ), 16'h1);
      chk("restart_ret", RETIRED,       16'd9);

      for (int i = 0; i < 600; i++) begin
         tick(($urandom % 4) == 0, ($urandom % 2) == 0,
              16'($urandom), 2'($urandom), 16'($urandom));
      end

      @(negedge CLK);
      do_reset();
      tick(1'b1, 1'b0, 16'h0, 2'b00, 16'h0);
      run_instr(16'h2000, 0, 2'b10, 16'h0ABC);
      tick(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
      chk("pre_rst_req", 16'(IMEM_REQ), 16'h1);
      #2;
      RST_N = 1'b0;
      model_reset();
      #1;
      chk("arst_req",    16'(IMEM_REQ), 16'h0);
      chk("arst_pc",     PC,            16'h0000);
      chk("arst_halted", 16'(HALTED),   16'h0);
      check_all();
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 3; i++)
         tick(1'b0, 1'b1, 16'h3456, 2'b00, 16'h0);
      chk("late_ack_req", 16'(IMEM_REQ), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream control stage for the 16-bit ALU datapath.
- Holds the program counter and fetches 16-bit instruction words from instruction memory over a req/ack handshake.
- Decodes each word into the ALU opcode and register/immediate fields, and presents them with a one-cycle valid strobe.
- Consumes the ALU's BRANCH outcome to choose the next PC; stops on the halt opcode.

Parameters:
- ADDR_W, 16, width of PC and instruction address.
- RESET_PC, 16'h0000, PC value after reset and on restart.
- HALT_OP, 4'd1, opcode that stops sequencing.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begin or restart execution; level-sampled in IDLE and HALTED only.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  ADDR_W  fetch address; equals PC.
- IMEM_ACK  in  1  fetch complete; IMEM_DATA is valid in this cycle.
- IMEM_DATA  in  16  instruction word.
- OP  out  4  opcode, INSTR[15:12], to the ALU OP input.
- RA  out  4  INSTR[11:8].
- RB  out  4  INSTR[7:4].
- RC  out  4  INSTR[3:0].
- IMM8  out  8  INSTR[7:0].
- OP_VALID  out  1  one-cycle strobe when OP and the fields are newly valid.
- BRANCH  in  2  ALU branch outcome: 00 sequential, 01 relative taken, 10 absolute jump, 11 treated as 00.
- BR_TARGET  in  ADDR_W  absolute target, used when BRANCH=10.
- PC  out  ADDR_W  current PC.
- HALTED  out  1  high while in the HALTED state.
- RETIRED  out  16  count of completed instructions; wraps modulo 2^16.

Behaviour:
- Reset is asynchronous and active-low: RST_N=0 immediately forces state IDLE, PC=RESET_PC, IR=0, OP/RA/RB/RC/IMM8=0, OP_VALID=0, IMEM_REQ=0, HALTED=0, RETIRED=0. Reset mid-fetch abandons the request with no ack wait.
- States: IDLE, FETCH, DECODE, EXEC, HALTED. All outputs are registered.
- IDLE: START=1 -> FETCH on the next edge.
- FETCH:
  - IMEM_REQ=1 and IMEM_ADDR=PC, both held stable until ack.
  - On IMEM_ACK=1, capture IMEM_DATA into IR and go to DECODE; IMEM_REQ is 0 from the next cycle.
  - IMEM_ACK outside FETCH is ignored.
  - A same-cycle ack is allowed, giving a minimum fetch of 1 cycle; there is no timeout.
- DECODE:
  - OP/RA/RB/RC/IMM8 update from IR and OP_VALID=1 for exactly this one cycle.
  - If IR[15:12]==HALT_OP -> HALTED; OP_VALID still pulses. Otherwise -> EXEC.
- EXEC (fields held, OP_VALID=0):
  - Sample BRANCH. Next PC: 00/11 -> PC+1; 01 -> PC+1+sext(IMM8); 10 -> BR_TARGET.
  - All PC arithmetic is modulo 2^ADDR_W: FFFF+1 = 0000, and negative offsets wrap.
  - RETIRED increments, then -> FETCH.
- Instruction throughput is 3 cycles with a zero-wait memory (FETCH, DECODE, EXEC).
- HALTED:
  - PC holds the halt instruction's address.
  - Halt does not increment RETIRED.
  - The OP fields hold the halt word.
  - START=1 -> PC=RESET_PC, RETIRED is kept, -> FETCH.
- START while busy (FETCH/DECODE/EXEC) is ignored.
- BRANCH is don't-care outside EXEC.

Decomposition:
- Shared package contains:
  - state encoding constants: IDLE, FETCH, DECODE, EXEC, HALTED;
  - opcode constants, including OP_HALT=4'd1;
  - BRANCH codes: BR_SEQ=2'b00, BR_REL=2'b01, BR_ABS=2'b10;
  - instruction field bit positions.
- One natural sub-module, next_pc_calc: a combinational next-PC mux/adder taking PC, IMM8, BRANCH and BR_TARGET.
- FSM, IR, and counters stay in fetch_sequencer.

Test Plan:
- Reset/start: RST_N low for 3 cycles, then START=1 with zero-wait ack and IMEM_DATA=16'h2345 -> IMEM_ADDR=0000; DECODE shows OP=2, RA=3, RB=4, RC=5, IMM8=45 with a single OP_VALID pulse; after EXEC (BRANCH=00) PC=0001 and RETIRED=1.
- Wait states: hold IMEM_ACK low for 4 cycles -> IMEM_REQ stays high and IMEM_ADDR is stable throughout; OP_VALID fires exactly 1 cycle after the ack edge.
- Branches:
  - PC=0010 with IMM8=FE, BRANCH=01 -> next PC=000F.
  - BRANCH=10 with BR_TARGET=1234 -> PC=1234.
  - BRANCH=11 -> PC+1.
- Wrap: PC=FFFF with BRANCH=00 -> PC=0000. PC=0000 with IMM8=80, BRANCH=01 -> PC=FF81.
- Halt: fetch 16'h1000 at PC=0005 -> OP_VALID pulses with OP=1, HALTED=1, PC stays 0005, IMEM_REQ=0, RETIRED unchanged. Then START -> PC=0000, fetch resumes.
- Async reset mid-fetch: drop RST_N while IMEM_REQ=1 -> IMEM_REQ=0, PC=0000, HALTED=0 with no clock edge; a late IMEM_ACK afterwards is ignored.
